// File: rtl/sw_cond_pkg.sv
// Shared constants for the switch conditioner.
//   DEFAULT_WIDTH           - number of board slide switches
//   DEFAULT_DEBOUNCE_CYCLES - 10 ms at 100 MHz
//   SIM_DEBOUNCE_CYCLES     - short window for simulation builds
//   startup_cycles()        - cycles from reset release until held switches are stable
package sw_cond_pkg;

    localparam int unsigned DEFAULT_WIDTH           = 7;
    localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 1000000;
    localparam int unsigned SIM_DEBOUNCE_CYCLES     = 4;

    // Two synchronizer stages plus the full debounce window.
    function automatic int unsigned startup_cycles(input int unsigned debounce_cycles);
        return debounce_cycles + 2;
    endfunction

endpackage

// File: rtl/debounce_bit.sv
// Conditions one raw switch: 2-flop synchronizer, debounce counter, stable level and
// optional registered rise/fall pulses.
// Optional feature macro: SW_COND_EDGE_EN (when undefined, rise_o/fall_o are tied to 0).
// Ports:
//   clk_i    - system clock
//   rst_i    - asynchronous active-high reset
//   raw_i    - raw switch pin, asynchronous to clk_i
//   en_i     - pulse enable (start-up window has already elapsed)
//   stable_o - debounced level
//   rise_o   - one-cycle pulse when stable_o first shows a 0->1 update
//   fall_o   - one-cycle pulse when stable_o first shows a 1->0 update
module debounce_bit
    import sw_cond_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic raw_i,
    input  logic en_i,
    output logic stable_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync2_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             stable_q, stable_d;
    logic             update;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            cnt_q    <= '0;
            stable_q <= 1'b0;
        end else begin
            sync1_q  <= raw_i;
            sync2_q  <= sync1_q;
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
        end
    end

    // Any cycle back at the stable level discards the run; no partial credit.
    always_comb begin
        cnt_d    = cnt_q;
        stable_d = stable_q;
        update   = 1'b0;
        if (sync2_q == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            stable_d = sync2_q;
            cnt_d    = '0;
            update   = 1'b1;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign stable_o = stable_q;

`ifdef SW_COND_EDGE_EN
    logic rise_q, fall_q;

    // Registered alongside stable_q so the pulse lines up with the new level.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            rise_q <= en_i & update & sync2_q;
            fall_q <= en_i & update & ~sync2_q;
        end
    end

    assign rise_o = rise_q;
    assign fall_o = fall_q;
`else
    logic unused_edge;
    assign unused_edge = en_i ^ update;
    assign rise_o      = 1'b0;
    assign fall_o      = 1'b0;
`endif

endmodule

// File: rtl/switch_conditioner.sv
// Input conditioning for the slide-switch bus: one debounce_bit per switch plus a
// start-up counter that raises sw_valid once held switches have propagated.
// Optional feature macro: SW_COND_EDGE_EN (edge pulses; tied to 0 when undefined).
// Ports:
//   clk       - system clock, all flops rising-edge
//   reset     - asynchronous active-high reset
//   sw_raw    - raw switch pins, asynchronous to clk
//   sw_stable - debounced switch levels
//   sw_rise   - per-bit one-cycle pulse on a stable 0->1 update
//   sw_fall   - per-bit one-cycle pulse on a stable 1->0 update
//   sw_valid  - sticky, high once the start-up window has elapsed
module switch_conditioner
    import sw_cond_pkg::*;
#(
    parameter int unsigned WIDTH           = DEFAULT_WIDTH,
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_stable,
    output logic [WIDTH-1:0] sw_rise,
    output logic [WIDTH-1:0] sw_fall,
    output logic             sw_valid
);

    // Counter value seen on the edge at which sw_valid first sets.
    localparam int unsigned START_LAST = startup_cycles(DEBOUNCE_CYCLES) - 1;
    localparam int unsigned START_W    = $clog2(START_LAST + 1);

    logic [START_W-1:0] start_cnt_q, start_cnt_d;
    logic               valid_q, valid_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            start_cnt_q <= '0;
            valid_q     <= 1'b0;
        end else begin
            start_cnt_q <= start_cnt_d;
            valid_q     <= valid_d;
        end
    end

    // Saturates at START_LAST; valid stays set until the next reset.
    always_comb begin
        start_cnt_d = start_cnt_q;
        valid_d     = valid_q;
        if (start_cnt_q == START_W'(START_LAST)) begin
            valid_d = 1'b1;
        end else begin
            start_cnt_d = start_cnt_q + 1'b1;
        end
    end

    assign sw_valid = valid_q;

    // Pulses are enabled by the pre-edge valid, so switches already on at power-up
    // update sw_stable on the same edge valid rises without producing a rise pulse.
    genvar i;
    for (i = 0; i < int'(WIDTH); i++) begin : g_bit
        debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce_bit (
            .clk_i   (clk),
            .rst_i   (reset),
            .raw_i   (sw_raw[i]),
            .en_i    (valid_q),
            .stable_o(sw_stable[i]),
            .rise_o  (sw_rise[i]),
            .fall_o  (sw_fall[i])
        );
    end

endmodule

// File: tb/tb_switch_conditioner.sv
module tb_switch_conditioner;
    import sw_cond_pkg::*;

    localparam int unsigned W = 7;
    localparam int unsigned D = SIM_DEBOUNCE_CYCLES;
`ifdef SW_COND_EDGE_EN
    localparam logic [W-1:0] EdgeMask = 7'h7F;
`else
    localparam logic [W-1:0] EdgeMask = 7'h00;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [W-1:0] sw_raw = '0;
    logic [W-1:0] sw_stable, sw_rise, sw_fall;
    logic         sw_valid;

    int checks = 0;
    int errors = 0;
    bit check_en = 1'b0;

    switch_conditioner #(
        .WIDTH(W),
        .DEBOUNCE_CYCLES(D)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .sw_raw   (sw_raw),
        .sw_stable(sw_stable),
        .sw_rise  (sw_rise),
        .sw_fall  (sw_fall),
        .sw_valid (sw_valid)
    );

    always #5 clk = ~clk;

    // Behavioural model: a bit's stable level flips on the edge where the last D
    // synchronized samples (raw as captured two edges earlier) all differ from it.
    logic [W-1:0] raw_hist[$];
    logic [W-1:0] m_stable = '0, m_rise = '0, m_fall = '0;
    logic         m_valid = 1'b0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            raw_hist.delete();
            m_stable = '0;
            m_rise   = '0;
            m_fall   = '0;
            m_valid  = 1'b0;
        end else begin
            int  n;
            bit  prev_valid;
            bit  all_diff;
            logic v;
            raw_hist.push_back(sw_raw);
            n          = raw_hist.size();
            prev_valid = m_valid;
            m_rise     = '0;
            m_fall     = '0;
            for (int b = 0; b < int'(W); b++) begin
                all_diff = 1'b1;
                for (int t = 0; t < int'(D); t++) begin
                    int idx;
                    idx = n - 3 - t;
                    v = (idx >= 0) ? raw_hist[idx][b] : 1'b0;
                    if (v == m_stable[b]) all_diff = 1'b0;
                end
                if (all_diff) begin
                    m_stable[b] = ~m_stable[b];
                    if (prev_valid) begin
                        if (m_stable[b]) m_rise[b] = EdgeMask[b];
                        else             m_fall[b] = EdgeMask[b];
                    end
                end
            end
            m_valid = (n >= int'(D) + 2);
        end
    end

    task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s at %0t: got %h want %h", name, $time, got, want);
        end
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            check("model sw_stable", sw_stable, m_stable);
            check("model sw_rise", sw_rise, m_rise);
            check("model sw_fall", sw_fall, m_fall);
            check("model sw_valid", W'(sw_valid), W'(m_valid));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        // Fresh reset, switches all off.
        #1 reset = 1'b1;
        check_en = 1'b1;
        tick(3);
        reset = 1'b0;
        check("rst stable", sw_stable, 7'h00);
        check("rst rise", sw_rise, 7'h00);
        check("rst fall", sw_fall, 7'h00);
        check("rst valid", W'(sw_valid), 7'h00);
        tick(5);
        check("off valid c5", W'(sw_valid), 7'h00);
        tick(1);
        check("off valid c6", W'(sw_valid), 7'h01);
        check("off stable c6", sw_stable, 7'h00);

        // Switches 0 and 2 on through reset: no rise pulses at start-up.
        reset = 1'b1;
        sw_raw = 7'h05;
        tick(2);
        reset = 1'b0;
        tick(5);
        check("pwr stable c5", sw_stable, 7'h00);
        check("pwr valid c5", W'(sw_valid), 7'h00);
        tick(1);
        check("pwr stable c6", sw_stable, 7'h05);
        check("pwr valid c6", W'(sw_valid), 7'h01);
        check("pwr rise c6", sw_rise, 7'h00);

        // Clean step on bit 3.
        sw_raw = 7'h0D;
        tick(5);
        check("step stable c5", sw_stable, 7'h05);
        check("step rise c5", sw_rise, 7'h00);
        tick(1);
        check("step stable c6", sw_stable, 7'h0D);
        check("step rise c6", sw_rise, 7'h08 & EdgeMask);
        tick(1);
        check("step rise c7", sw_rise, 7'h00);

        // Bring bit 2 low, then bounce it before settling high.
        sw_raw = 7'h09;
        tick(10);
        check("bit2 low", sw_stable, 7'h09);
        for (int k = 0; k < 4; k++) begin
            sw_raw[2] = (k % 2 == 0);
            tick(2);
        end
        check("bounce no update", sw_stable, 7'h09);
        sw_raw[2] = 1'b1;
        tick(5);
        check("bounce stable c5", sw_stable, 7'h09);
        tick(1);
        check("bounce stable c6", sw_stable, 7'h0D);
        check("bounce rise c6", sw_rise, 7'h04 & EdgeMask);
        tick(1);
        check("bounce rise c7", sw_rise, 7'h00);

        // All bits high, then all fall together.
        sw_raw = 7'h7F;
        tick(8);
        check("all on", sw_stable, 7'h7F);
        sw_raw = 7'h00;
        tick(5);
        check("all fall c5", sw_fall, 7'h00);
        tick(1);
        check("all stable c6", sw_stable, 7'h00);
        check("all fall c6", sw_fall, 7'h7F & EdgeMask);
        check("all rise c6", sw_rise, 7'h00);
        tick(1);
        check("all fall c7", sw_fall, 7'h00);

        // Reset while a 0->1 on bit 0 sits at debounce count 2.
        sw_raw = 7'h10;
        tick(10);
        sw_raw = 7'h11;
        tick(4);
        reset = 1'b1;
        #1;
        check("midrst stable", sw_stable, 7'h00);
        check("midrst valid", W'(sw_valid), 7'h00);
        check("midrst rise", sw_rise, 7'h00);
        tick(3);
        reset = 1'b0;
        tick(5);
        check("rerel stable c5", sw_stable, 7'h00);
        check("rerel valid c5", W'(sw_valid), 7'h00);
        tick(1);
        check("rerel stable c6", sw_stable, 7'h11);
        check("rerel valid c6", W'(sw_valid), 7'h01);
        check("rerel rise c6", sw_rise, 7'h00);
        tick(3);

        check_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
